// File: rtl/alu_sequencer.sv
// alu_sequencer: drives a/b/funct of the combinational ALU; latency S+2 (ops 0-3), 3S+4 (MUL/DIV), 1 (error).
// rsp held until rsp_ready, req_ready only in IDLE; define ALU_SEQ_DIVZERO_CHECK_EN to reject DIV by zero early.
module alu_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_op,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [2:0] alu_funct,
  input  logic [7:0] alu_result,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_hi,
  output logic [7:0] rsp_lo,
  output logic       rsp_err
);

  localparam logic [2:0] F_RD_HI = 3'b110;
  localparam logic [2:0] F_PARK  = 3'b111;
  localparam logic [3:0] LAST    = 4'(SETTLE_CYCLES);

  typedef enum logic [2:0] {IDLE, ISSUE, RD_HI, RD_LO, RESP} state_t;

  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [2:0] op, op_n;
  logic [7:0] a_n, b_n;
  logic [2:0] funct_n;
  logic       valid_n, err_n, ready_n;
  logic [7:0] hi_n, lo_n;
  logic       illegal, div_zero;

  always_comb begin
    illegal = (op == 3'd6) || (op == 3'd7);
`ifdef ALU_SEQ_DIVZERO_CHECK_EN
    div_zero = (op == 3'd5) && (alu_b == 8'd0);
`else
    div_zero = 1'b0;
`endif
  end

  // ISSUE cnt==0 is a decode cycle with funct still parked; cnt 1..LAST+1 hold the op code.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    op_n    = op;
    a_n     = alu_a;
    b_n     = alu_b;
    funct_n = alu_funct;
    valid_n = rsp_valid;
    hi_n    = rsp_hi;
    lo_n    = rsp_lo;
    err_n   = rsp_err;
    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          state_n = ISSUE;
          cnt_n   = 4'd0;
          op_n    = req_op;
          a_n     = req_a;
          b_n     = req_b;
          hi_n    = 8'd0;
          lo_n    = 8'd0;
          err_n   = 1'b0;
        end
      end
      ISSUE: begin
        if ((cnt == 4'd0) && (illegal || div_zero)) begin
          state_n = RESP;
          valid_n = 1'b1;
          err_n   = 1'b1;
          hi_n    = illegal ? 8'h00 : 8'hFF;
          lo_n    = illegal ? 8'h00 : 8'hFF;
        end else if (cnt == LAST + 4'd1) begin
          cnt_n = 4'd0;
          if (op[2]) begin
            state_n = RD_HI;
            funct_n = F_RD_HI;
          end else begin
            state_n = RESP;
            valid_n = 1'b1;
            hi_n    = 8'd0;
            lo_n    = alu_result;
          end
        end else begin
          cnt_n   = cnt + 4'd1;
          funct_n = op;
        end
      end
      RD_HI: begin
        if (cnt == LAST) begin
          state_n = RD_LO;
          cnt_n   = 4'd0;
          hi_n    = alu_result;
          funct_n = F_PARK;
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end
      RD_LO: begin
        if (cnt == LAST) begin
          state_n = RESP;
          cnt_n   = 4'd0;
          lo_n    = alu_result;
          valid_n = 1'b1;
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_n = IDLE;
          valid_n = 1'b0;
          funct_n = F_PARK;
        end
      end
      default: begin
        state_n = IDLE;
        valid_n = 1'b0;
        funct_n = F_PARK;
      end
    endcase
    ready_n = (state_n == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      op        <= 3'd0;
      alu_a     <= 8'd0;
      alu_b     <= 8'd0;
      alu_funct <= F_PARK;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_hi    <= 8'd0;
      rsp_lo    <= 8'd0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      op        <= op_n;
      alu_a     <= a_n;
      alu_b     <= b_n;
      alu_funct <= funct_n;
      req_ready <= ready_n;
      rsp_valid <= valid_n;
      rsp_hi    <= hi_n;
      rsp_lo    <= lo_n;
      rsp_err   <= err_n;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural funct-driven ALU plus a response scoreboard.
module tb_alu_sequencer;

  localparam int S = 1;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [2:0] req_op = 3'd0;
  logic [7:0] req_a = 8'd0;
  logic [7:0] req_b = 8'd0;
  logic [7:0] alu_a, alu_b;
  logic [2:0] alu_funct;
  logic [7:0] alu_result = 8'd0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [7:0] rsp_hi, rsp_lo;
  logic       rsp_err;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [2:0] op;
    logic       err;
    logic [7:0] hi;
    logic [7:0] lo;
    int         lat;
  } exp_t;

  exp_t       sb[$];
  logic [2:0] flog[$];

  alu_sequencer #(.SETTLE_CYCLES(S)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_funct(alu_funct), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_hi(rsp_hi), .rsp_lo(rsp_lo), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // ALU recomputes only on a funct change; 110/111 read back the MUL/DIV high/low bytes.
  logic [7:0] alu_hi = 8'd0;
  logic [7:0] alu_lo = 8'd0;
  always @(alu_funct) begin
    case (alu_funct)
      3'd0: alu_result = alu_a & alu_b;
      3'd1: alu_result = ~(alu_a | alu_b);
      3'd2: alu_result = alu_a + alu_b;
      3'd3: alu_result = alu_a - alu_b;
      3'd4: begin
        {alu_hi, alu_lo} = 16'(alu_a) * 16'(alu_b);
        alu_result = alu_lo;
      end
      3'd5: begin
        if (alu_b == 8'd0) begin
          alu_hi = alu_a;
          alu_lo = 8'hFF;
        end else begin
          alu_hi = alu_a % alu_b;
          alu_lo = alu_a / alu_b;
        end
        alu_result = alu_lo;
      end
      3'd6: alu_result = alu_hi;
      default: alu_result = alu_lo;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    e.op  = op;
    e.err = 1'b0;
    e.hi  = 8'd0;
    e.lo  = 8'd0;
    case (op)
      3'd0: e.lo = a & b;
      3'd1: e.lo = ~(a | b);
      3'd2: e.lo = a + b;
      3'd3: e.lo = a - b;
      3'd4: {e.hi, e.lo} = 16'(a) * 16'(b);
      3'd5: begin
        if (b == 8'd0) begin
`ifdef ALU_SEQ_DIVZERO_CHECK_EN
          e.err = 1'b1;
          e.hi  = 8'hFF;
          e.lo  = 8'hFF;
`else
          e.hi = a;
          e.lo = 8'hFF;
`endif
        end else begin
          e.hi = a % b;
          e.lo = a / b;
        end
      end
      default: e.err = 1'b1;
    endcase
    if (e.err) e.lat = 1;
    else if (op < 3'd4) e.lat = S + 2;
    else e.lat = 3 * S + 4;
    return e;
  endfunction

  // Expected funct in cycle idx after the accept edge.
  function automatic logic [2:0] exp_funct(input exp_t e, input int idx);
    int step;
    if (idx == 0 || e.err) return 3'b111;
    step = (idx - 1) / (S + 1);
    if (step == 0) return e.op;
    if (step == 1) return 3'b110;
    return 3'b111;
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input int hold);
    exp_t e;
    int   lat;
    int   n;
    sb.push_back(model(op, a, b));
    flog.delete();
    if (hold > 0) rsp_ready = 1'b0;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check($sformatf("op%0d req_ready wait", op), 32'(req_ready), 1);
    req_valid = 1'b1;
    req_op = op;
    req_a = a;
    req_b = b;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    flog.push_back(alu_funct);
    lat = 0;
    while (!rsp_valid && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
      flog.push_back(alu_funct);
    end
    e = sb.pop_front();
    check($sformatf("op%0d rsp_valid", op), 32'(rsp_valid), 1);
    check($sformatf("op%0d latency", op), 32'(lat), 32'(e.lat));
    check($sformatf("op%0d rsp_hi", op), 32'(rsp_hi), 32'(e.hi));
    check($sformatf("op%0d rsp_lo", op), 32'(rsp_lo), 32'(e.lo));
    check($sformatf("op%0d rsp_err", op), 32'(rsp_err), 32'(e.err));
    for (int i = 0; i < lat && i < flog.size(); i++)
      check($sformatf("op%0d funct[%0d]", op, i), 32'(flog[i]), 32'(exp_funct(e, i)));
    if (hold > 0) begin
      req_valid = 1'b1;
      req_op = 3'd2;
      req_a = 8'h11;
      req_b = 8'h22;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        #1;
        check("bp rsp_valid", 32'(rsp_valid), 1);
        check("bp rsp_lo", 32'(rsp_lo), 32'(e.lo));
        check("bp req_ready", 32'(req_ready), 0);
      end
      check("bp alu_a", 32'(alu_a), 32'(a));
      req_valid = 1'b0;
      rsp_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    check($sformatf("op%0d hs rsp_valid", op), 32'(rsp_valid), 0);
    check($sformatf("op%0d hs park", op), 32'(alu_funct), 32'(3'b111));
    check($sformatf("op%0d hs req_ready", op), 32'(req_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int seen;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst funct", 32'(alu_funct), 32'(3'b111));
    check("rst alu_a", 32'(alu_a), 0);
    check("rst alu_b", 32'(alu_b), 0);
    check("rst req_ready", 32'(req_ready), 0);
    check("rst rsp_valid", 32'(rsp_valid), 0);
    check("rst rsp_hi", 32'(rsp_hi), 0);
    check("rst rsp_lo", 32'(rsp_lo), 0);
    check("rst rsp_err", 32'(rsp_err), 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("rel req_ready", 32'(req_ready), 1);

    run_op(3'd2, 8'h3C, 8'h05, 0);
    run_op(3'd4, 8'h20, 8'h10, 0);
    run_op(3'd5, 8'd200, 8'd7, 0);
    run_op(3'd0, 8'hF0, 8'h3C, 0);
    run_op(3'd0, 8'h0F, 8'hFF, 0);
    run_op(3'd1, 8'hA5, 8'h0F, 0);
    run_op(3'd4, 8'hFF, 8'hFF, 0);
    run_op(3'd2, 8'hF0, 8'h20, 0);
    run_op(3'd5, 8'd9, 8'd0, 0);
    run_op(3'd3, 8'h05, 8'h07, 5);
    run_op(3'd6, 8'h12, 8'h34, 0);
    run_op(3'd7, 8'h56, 8'h78, 0);

    // Abort a MUL during its high-byte read.
    @(negedge clk);
    req_valid = 1'b1;
    req_op = 3'd4;
    req_a = 8'h33;
    req_b = 8'h44;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    n = 0;
    while (alu_funct != 3'b110 && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("abort reach rd_hi", 32'(alu_funct), 32'(3'b110));
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort funct", 32'(alu_funct), 32'(3'b111));
    check("abort rsp_valid", 32'(rsp_valid), 0);
    check("abort req_ready", 32'(req_ready), 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("abort rel req_ready", 32'(req_ready), 1);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (rsp_valid) seen = 1;
    end
    check("abort no rsp", 32'(seen), 0);

    run_op(3'd2, 8'h01, 8'h02, 0);
    check("sb empty", 32'(sb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
